// File: rtl/audio_feeder_pkg.sv
// Shared types and constants for the audio playback feeder: sample and stereo-pair
// types, the request-alignment state enum and the volume scaling helper.
package audio_feeder_pkg;

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_pair_t;

  typedef enum logic {
    WAIT_L = 1'b0,
    WAIT_R = 1'b1
  } feeder_state_t;

  localparam logic [15:0] UNDERRUN_SAT = 16'hFFFF;

  // Attenuation is a sign-preserving shift, so full negative scale decays to -1, not 0.
  function automatic sample_t scale_sample(input sample_t s, input logic [3:0] vol);
    return s >>> vol;
  endfunction

endpackage

// File: rtl/stereo_sample_fifo.sv
// DEPTH-entry FIFO of stereo pairs with a show-ahead head; level reaches exactly DEPTH.
module stereo_sample_fifo
  import audio_feeder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  stereo_pair_t             wr_data,
  output stereo_pair_t             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  stereo_pair_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: non-blocking assignments on every register so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/audio_playback_feeder.sv
// Feeds buffered stereo pairs to a codec on left/right request pulses with volume scaling.
// Optional: define AUDIO_FEEDER_UNDERRUN_REPEAT_EN to repeat the last pair on underrun.
module audio_playback_feeder
  import audio_feeder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_left,
  input  logic [15:0]            in_right,
  input  logic [1:0]             sample_req,
  input  logic [3:0]             volume_control,
  output logic [15:0]            audio_output,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            underrun_count
);

  stereo_pair_t  head;
  stereo_pair_t  wr_pair;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          load_out;
  logic          underrun;
  feeder_state_t state;
  feeder_state_t state_next;
  sample_t       hold;
  sample_t       hold_next;
  sample_t       out_next;
`ifdef AUDIO_FEEDER_UNDERRUN_REPEAT_EN
  sample_t       last_left;
  sample_t       last_left_next;
`endif

  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign wr_pair  = '{left: in_left, right: in_right};

  stereo_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_pair),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_L;
    else       state <= state_next;
  end

  // A left request is handled identically from either state, which is what gives
  // resync from WAIT_R and left priority when both request bits arrive together.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    out_next   = '0;
    load_out   = 1'b0;
    pop        = 1'b0;
    underrun   = 1'b0;
`ifdef AUDIO_FEEDER_UNDERRUN_REPEAT_EN
    last_left_next = last_left;
`endif
    if (sample_req[1]) begin
      load_out   = 1'b1;
      state_next = WAIT_R;
      if (!empty) begin
        pop       = 1'b1;
        out_next  = scale_sample(head.left, volume_control);
        hold_next = head.right;
`ifdef AUDIO_FEEDER_UNDERRUN_REPEAT_EN
        last_left_next = head.left;
`endif
      end else begin
        underrun = 1'b1;
`ifdef AUDIO_FEEDER_UNDERRUN_REPEAT_EN
        // hold still carries the right half of the last popped pair
        out_next = scale_sample(last_left, volume_control);
`else
        out_next  = '0;
        hold_next = '0;
`endif
      end
    end else if (sample_req[0]) begin
      load_out   = 1'b1;
      out_next   = scale_sample(hold, volume_control);
      state_next = WAIT_L;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      audio_output   <= '0;
      hold           <= '0;
      underrun_count <= '0;
`ifdef AUDIO_FEEDER_UNDERRUN_REPEAT_EN
      last_left      <= '0;
`endif
    end else begin
      hold <= hold_next;
      if (load_out) audio_output <= out_next;
      if (underrun && (underrun_count != UNDERRUN_SAT)) underrun_count <= underrun_count + 1'b1;
`ifdef AUDIO_FEEDER_UNDERRUN_REPEAT_EN
      last_left      <= last_left_next;
`endif
    end
  end

endmodule

// File: doc/audio_playback_feeder.md
AUDIO_PLAYBACK_FEEDER -- requirements
Module: audio_playback_feeder

Interface
REQ-001 Parameter: DEPTH, 16, number of stereo pairs buffered (power of two, 4..256).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  producer offers a stereo pair.
REQ-005 Port: in_ready  output  1  feeder accepts the pair this cycle.
REQ-006 Port: in_left  input  16  left sample, two's complement.
REQ-007 Port: in_right  input  16  right sample, two's complement.
REQ-008 Port: sample_req  input  2  codec request pulses; [1] left, [0] right.
REQ-009 Port: volume_control  input  4  attenuation; 0 full scale, 15 maximum.
REQ-010 Port: audio_output  output  16  sample presented to codec.
REQ-011 Port: fifo_level  output  $clog2(DEPTH)+1  pairs currently stored.
REQ-012 Port: underrun_count  output  16  saturating count of left requests with FIFO empty.

Function
REQ-013 SHALL store pairs in a DEPTH-entry FIFO; push when in_valid && in_ready.
REQ-014 SHALL drive in_ready = (fifo_level != DEPTH) && !reset, combinationally.
REQ-015 SHALL implement two states: WAIT_L (expect left request) and WAIT_R (expect right request).
REQ-016 In WAIT_L on sample_req[1]: pop one pair if non-empty, register scaled left onto audio_output, latch right into hold register, go WAIT_R.
REQ-017 In WAIT_R on sample_req[0]: register scaled held right onto audio_output, go WAIT_L.
REQ-018 audio_output SHALL update exactly one clock after the request pulse and hold until the next request.
REQ-019 sample_req[0] in WAIT_L (start-up misalignment): output scaled hold register, remain WAIT_L, no pop.
REQ-020 sample_req[1] in WAIT_R: treat as a new left request per REQ-016 (resync).
REQ-021 Both sample_req bits high in one cycle: left SHALL take priority; right ignored.
REQ-022 Left request with FIFO empty: underrun; no pop; underrun_count +1, saturating at 16'hFFFF; output per REQ-029.
REQ-023 Scaling: arithmetic right shift of sample by volume_control, sign preserved (e.g. 16'h8000 >>> 15 = 16'hFFFF).
REQ-024 volume_control SHALL be sampled at the request cycle; mid-frame changes affect the next request only.
REQ-025 Simultaneous push and pop: both occur; fifo_level unchanged; push into full FIFO never occurs (in_ready low).
REQ-026 Pointers SHALL wrap modulo DEPTH; fifo_level SHALL reach exactly DEPTH when full.

Reset
REQ-027 On reset: FIFO empty, fifo_level 0, state WAIT_L, audio_output 16'h0000, hold register 0, underrun_count 0, in_ready 0.
REQ-028 Reset mid-frame SHALL discard buffered pairs and any pending right sample; first request after reset handled per WAIT_L.

Configuration
REQ-029 Macro AUDIO_FEEDER_UNDERRUN_REPEAT_EN: defined -> on underrun re-output the last popped pair (left now, right at next right request); undefined -> output 16'h0000 for both channels.

Structure
REQ-030 Package audio_feeder_pkg SHALL hold the 16-bit sample type, the stereo-pair struct, the state enum, and the saturation constant.
REQ-031 FIFO storage/pointers SHALL be sub-module stereo_sample_fifo (push/pop/full/empty/level); FSM, scaling and counters in the top.

Verification
REQ-032 Push (16'h1234,16'hABCD), vol 0, pulse req[1] then req[0] -> audio_output 16'h1234 one cycle after req[1], 16'hABCD one cycle after req[0].
REQ-033 Push (16'h8000,16'h7FFF), vol 4 -> left 16'hF800, right 16'h07FF.
REQ-034 Push DEPTH pairs without requests -> in_ready 0, fifo_level DEPTH; one left request -> in_ready 1 next cycle, level DEPTH-1.
REQ-035 Empty FIFO, three left requests -> underrun_count 3; output 16'h0000 (macro undefined) or last pair values (macro defined).
REQ-036 req[0] first after reset, then req[1] with pair (16'h0001,16'h0002) queued -> outputs 16'h0000, then 16'h0001; req[1] and req[0] same cycle -> left only.
REQ-037 Reset asserted in WAIT_R with 3 pairs buffered -> fifo_level 0, audio_output 16'h0000, next req[1] counts an underrun.
